// File: rtl/pipe_addsub.sv
// Carry-pipelined adder/subtractor: L = N/K stages, each adding one K-bit chunk.
// Upper operand chunks travel through skew registers, finished low chunks through de-skew registers.
module pipe_addsub #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int L = N / K;

  logic         adv;
  logic [N-1:0] b_eff;
  logic         cin_eff;
  logic         ovf_q;

  // Subtraction is a + ~b + ~cin, so op_sub is folded into the operands once at entry.
  assign b_eff    = b ^ {N{op_sub}};
  assign cin_eff  = cin ^ op_sub;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar i = 0; i < L; i++) begin : g_stage
    logic [K-1:0]       ach;
    logic [K-1:0]       bch;
    logic               ci;
    logic               vi;
    logic [K:0]         part;
    logic [(i+1)*K-1:0] s_d;
    logic               v_q;
    logic               c_q;
    logic [(i+1)*K-1:0] s_q;

    if (i == 0) begin : g_src
      assign ach = a[K-1:0];
      assign bch = b_eff[K-1:0];
      assign ci  = cin_eff;
      assign vi  = in_valid;
      assign s_d = part[K-1:0];
    end else begin : g_src
      assign ach = g_stage[i-1].g_skew.a_q[K-1:0];
      assign bch = g_stage[i-1].g_skew.b_q[K-1:0];
      assign ci  = g_stage[i-1].c_q;
      assign vi  = g_stage[i-1].v_q;
      assign s_d = {part[K-1:0], g_stage[i-1].s_q};
    end

    assign part = {1'b0, ach} + {1'b0, bch} + {{K{1'b0}}, ci};

    // NOTE: non-blocking assignments make every stage sample its predecessor's
    // pre-edge value; blocking ones would let data race through several stages per clock.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= vi;
        c_q <= part[K];
        s_q <= s_d;
      end
    end

    // Operand chunks not yet consumed ride along, shifted so the next chunk sits at bit 0.
    if (i < L - 1) begin : g_skew
      localparam int UW = N - (i + 1) * K;
      logic [UW-1:0] a_d;
      logic [UW-1:0] b_d;
      logic [UW-1:0] a_q;
      logic [UW-1:0] b_q;

      if (i == 0) begin : g_tap
        assign a_d = a[N-1:K];
        assign b_d = b_eff[N-1:K];
      end else begin : g_tap
        assign a_d = g_stage[i-1].g_skew.a_q[UW+K-1:K];
        assign b_d = g_stage[i-1].g_skew.b_q[UW+K-1:K];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // The last chunk holds both operand MSBs, so overflow is resolved there.
    if (i == L - 1) begin : g_ovf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= (ach[K-1] == bch[K-1]) && (part[K-1] != ach[K-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[L-1].v_q;
  assign sum       = g_stage[L-1].s_q;
  assign cout      = g_stage[L-1].c_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: a 16-bit/4-stage instance and a 4-bit/1-stage instance,
// both scored against an arithmetic reference model under directed and random traffic.
module tb_pipe_addsub;

  localparam int N  = 16;
  localparam int K  = 4;
  localparam int L  = N / K;
  localparam int N1 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout, ovf;
  logic [N-1:0]  a, b, sum;
  logic          in_valid1, in_ready1, cin1, op_sub1, out_valid1, out_ready1, cout1, ovf1;
  logic [N1-1:0] a1, b1, sum1;

  pipe_addsub #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_addsub #(.N(N1), .K(N1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .op_sub(op_sub1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          timed;
  } exp_t;

  exp_t        q16[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          timed  = 1'b0;
  bit          acc16, acc1;
  bit          stall16 = 1'b0;
  logic [17:0] held16, last16;
  logic [5:0]  last1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values; cout is carry (add) or not-borrow (sub),
  // ovf is whether the true signed result falls outside the w-bit signed range.
  function automatic exp_t model(input int w, input int av, input int bv, input int c, input int s);
    exp_t e;
    int   m, u, sa, sb, r;
    m = 1 << w;
    if (s == 0) begin
      u      = av + bv + c;
      e.cout = (u >= m);
      e.sum  = 16'(u % m);
    end else begin
      u      = av - bv - c;
      e.cout = (u >= 0);
      e.sum  = 16'((u + m) % m);
    end
    sa    = (av >= m / 2) ? av - m : av;
    sb    = (bv >= m / 2) ? bv - m : bv;
    r     = (s != 0) ? sa - sb - c : sa + sb + c;
    e.ovf = (r < -(m / 2)) || (r >= m / 2);
    e.acc   = 0;
    e.timed = 1'b0;
    return e;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Called at a falling edge with inputs already driven; observes, scores, then advances one cycle.
  task automatic step();
    exp_t e;
    #1;
    check("in_ready16", 32'(in_ready), 32'(!out_valid || out_ready));
    if (stall16) begin
      check("hold_valid16", 32'(out_valid), 32'd1);
      check("hold_data16", 32'({ovf, cout, sum}), 32'(held16));
    end
    stall16 = out_valid && !out_ready;
    held16  = {ovf, cout, sum};
    if (out_valid && out_ready) begin
      last16 = {ovf, cout, sum};
      if (q16.size() == 0) begin
        check("spurious16", 32'(out_valid), 32'd0);
      end else begin
        e = q16.pop_front();
        check("sum16", 32'(sum), 32'(e.sum));
        check("cout16", 32'(cout), 32'(e.cout));
        check("ovf16", 32'(ovf), 32'(e.ovf));
        if (e.timed) check("latency16", 32'(cyc - e.acc), 32'(L));
      end
    end
    acc16 = in_valid && in_ready;
    if (acc16) begin
      e       = model(N, int'(a), int'(b), int'(cin), int'(op_sub));
      e.acc   = cyc;
      e.timed = timed;
      q16.push_back(e);
    end

    check("in_ready1", 32'(in_ready1), 32'(!out_valid1 || out_ready1));
    if (out_valid1 && out_ready1) begin
      last1 = {ovf1, cout1, sum1};
      if (q1.size() == 0) begin
        check("spurious1", 32'(out_valid1), 32'd0);
      end else begin
        e = q1.pop_front();
        check("sum1", 32'(sum1), 32'(e.sum));
        check("cout1", 32'(cout1), 32'(e.cout));
        check("ovf1", 32'(ovf1), 32'(e.ovf));
        check("latency1", 32'(cyc - e.acc), 32'd1);
      end
    end
    acc1 = in_valid1 && in_ready1;
    if (acc1) begin
      e     = model(N1, int'(a1), int'(b1), int'(cin1), int'(op_sub1));
      e.acc = cyc;
      q1.push_back(e);
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && (q16.size() != 0 || q1.size() != 0); t++) step();
    check(tag, 32'(q16.size() + q1.size()), 32'd0);
  endtask

  task automatic run_one(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s,
                         input logic [17:0] exp_res);
    timed     = 1'b1;
    a         = av;
    b         = bv;
    cin       = c;
    op_sub    = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    last16    = 'x;
    step();
    check("accept16", 32'(acc16), 32'd1);
    drain("drain_directed");
    check("directed16", 32'(last16), 32'(exp_res));
    timed = 1'b0;
  endtask

  initial begin
    in_valid   = 1'b0; a  = '0; b  = '0; cin  = 1'b0; op_sub  = 1'b0; out_ready  = 1'b1;
    in_valid1  = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; op_sub1 = 1'b0; out_ready1 = 1'b1;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed corner cases on the 4-stage instance: {ovf, cout, sum}.
    run_one(16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002});
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    run_one(16'h0005, 16'h0006, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF});
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    run_one(16'h0009, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0005});

    // Single-stage instance: 5 + 6 + 1 = 0xC, signed overflow, result one cycle later.
    a1 = 4'h5; b1 = 4'h6; cin1 = 1'b1; op_sub1 = 1'b0; in_valid1 = 1'b1;
    last1 = 'x;
    step();
    check("accept1", 32'(acc1), 32'd1);
    in_valid1 = 1'b0;
    step();
    check("directed1", 32'(last1), 32'({1'b1, 1'b0, 4'hC}));

    // Eight back-to-back mixed ops with the consumer stalling for three cycles.
    begin
      int k  = 0;
      int it = 0;
      while (k < 8 && it < 40) begin
        if (it == 0 || acc16) begin
          a      = 16'($urandom);
          b      = 16'($urandom);
          cin    = 1'($urandom);
          op_sub = k[0];
        end
        in_valid  = 1'b1;
        out_ready = !(it >= 5 && it < 8);
        step();
        if (it == 6) check("stall_in_ready", 32'(in_ready), 32'd0);
        if (acc16) k++;
        it++;
      end
      check("stall_ops_accepted", 32'(k), 32'd8);
      drain("drain_stall");
    end

    // Reset with three ops in flight, one of them already on the output.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 16'h1234 + 16'(k); b = 16'h0101; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);
    q16.delete();
    q1.delete();
    stall16 = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step();
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    run_one(16'h0102, 16'h0304, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0407});

    // Random traffic on both instances with random bubbles and back-pressure.
    for (int t = 0; t < 500; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom);
      op_sub    = 1'($urandom);
      in_valid1 = ($urandom_range(0, 1) != 0);
      a1        = 4'($urandom);
      b1        = 4'($urandom);
      cin1      = 1'($urandom);
      op_sub1   = 1'($urandom);
      step();
    end
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
